// File: rtl/mips_muldiv_unit_if.sv
// Request/result bundle between the MIPS datapath and the multiply/divide unit.
// The abort line exists only when MULDIV_ABORT_EN is defined.
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             DivByZero;
`ifdef MULDIV_ABORT_EN
    logic             abort;

    modport master (
        output start, op, SrcA, SrcB, abort,
        input  busy, done, Hi, Lo, DivByZero
    );

    modport slave (
        input  start, op, SrcA, SrcB, abort,
        output busy, done, Hi, Lo, DivByZero
    );
`else
    modport master (
        output start, op, SrcA, SrcB,
        input  busy, done, Hi, Lo, DivByZero
    );

    modport slave (
        input  start, op, SrcA, SrcB,
        output busy, done, Hi, Lo, DivByZero
    );
`endif
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring divide,
// one bit per clock on magnitudes, with sign correction in a final FIX cycle.
// Optional feature macro: MULDIV_ABORT_EN (adds abort in RUN/FIX).
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic                clk,
    input logic                reset,
    mips_muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               is_div_r;
    logic               neg_q_r;    // product/quotient sign differs from magnitude
    logic               neg_a_r;    // dividend was negative (remainder sign)
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH:0]     acc_r;      // partial product high half / partial remainder
    logic [WIDTH-1:0]   q_r;        // multiplier being consumed / quotient being built
    logic [WIDTH-1:0]   opnd_r;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               dbz_r;

    logic               abort_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic               dbz_s;

`ifdef MULDIV_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    // Operand magnitudes and signs as seen at the sampling edge
    always_comb begin
        a_neg_s = bus.op[0] & bus.SrcA[WIDTH-1];
        b_neg_s = bus.op[0] & bus.SrcB[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = -bus.SrcA;
        end else begin
            a_mag_s = bus.SrcA;
        end
        if (b_neg_s) begin
            b_mag_s = -bus.SrcB;
        end else begin
            b_mag_s = bus.SrcB;
        end
    end

    // One multiply step and one restoring-divide step, plus the FIX-stage sign correction
    always_comb begin
        if (q_r[0]) begin
            mul_sum_s = acc_r + {1'b0, opnd_r};
        end else begin
            mul_sum_s = acc_r;
        end
        div_shift_s = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};

        prod_s = {acc_r[WIDTH-1:0], q_r};
        dbz_s  = is_div_r & (opnd_r == {WIDTH{1'b0}});
        if (neg_q_r) begin
            prod_fix_s = -prod_s;
        end else begin
            prod_fix_s = prod_s;
        end
        // Divide by zero leaves the loop with quotient all ones and remainder |SrcA|;
        // the remainder sign fix then restores the original SrcA in Hi.
        if (dbz_s) begin
            quo_fix_s = {WIDTH{1'b1}};
        end else if (neg_q_r) begin
            quo_fix_s = -q_r;
        end else begin
            quo_fix_s = q_r;
        end
        if (neg_a_r) begin
            rem_fix_s = -acc_r[WIDTH-1:0];
        end else begin
            rem_fix_s = acc_r[WIDTH-1:0];
        end
    end

    // Next-state logic; abort pre-empts the RUN/FIX transitions
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort_s) begin
                    state_s = IDLE;
                end else if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX: begin
                if (abort_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_a_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {(WIDTH+1){1'b0}};
            q_r      <= {WIDTH{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            dbz_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        is_div_r <= bus.op[1];
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_a_r  <= a_neg_s;
                        cnt_r    <= {CNT_W{1'b0}};
                        acc_r    <= {(WIDTH+1){1'b0}};
                        if (bus.op[1]) begin
                            q_r    <= a_mag_s;
                            opnd_r <= b_mag_s;
                        end else begin
                            q_r    <= b_mag_s;
                            opnd_r <= a_mag_s;
                        end
                    end
                end
                RUN: begin
                    if (!abort_s) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (is_div_r) begin
                            if (!div_diff_s[WIDTH+1]) begin
                                acc_r <= div_diff_s[WIDTH:0];
                                q_r   <= {q_r[WIDTH-2:0], 1'b1};
                            end else begin
                                acc_r <= div_shift_s;
                                q_r   <= {q_r[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            acc_r <= {1'b0, mul_sum_s[WIDTH:1]};
                            q_r   <= {mul_sum_s[0], q_r[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!abort_s) begin
                        if (is_div_r) begin
                            hi_r  <= rem_fix_s;
                            lo_r  <= quo_fix_s;
                            dbz_r <= dbz_s;
                        end else begin
                            hi_r  <= prod_fix_s[2*WIDTH-1:WIDTH];
                            lo_r  <= prod_fix_s[WIDTH-1:0];
                            dbz_r <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy      = (state_r != IDLE);
    assign bus.done      = (state_r == DONE);
    assign bus.Hi        = hi_r;
    assign bus.Lo        = lo_r;
    assign bus.DivByZero = dbz_r;
endmodule
